lab2_proc_imm_gen_pipe: RTL and testbench
=========================================

LAB2_PROC_IMM_GEN_PIPE -- requirements
Module: lab2_proc_imm_gen_pipe

Interface
REQ-001 SHALL have parameter p_xlen, default 32, output immediate width; legal values 32 and 64.
REQ-002 SHALL have parameter p_nstages, default 2, pipeline depth; legal values 1..4.
REQ-003 SHALL have parameter p_tag_nbits, default 4, width of the passthrough tag.
REQ-004 SHALL have port clk, input, 1, sole clock; all state updates on its rising edge.
REQ-005 SHALL have port reset, input, 1, asynchronous, active-low reset.
REQ-006 SHALL have port squash, input, 1, kills all in-flight entries.
REQ-007 SHALL have ports in_val (input, 1) and in_rdy (output, 1), the input handshake.
REQ-008 SHALL have port in_imm_type, input, 3, immediate type select.
REQ-009 SHALL have port in_inst, input, 32, raw instruction word.
REQ-010 SHALL have port in_tag, input, p_tag_nbits, opaque tag carried with the entry.
REQ-011 SHALL have ports out_val (output, 1) and out_rdy (input, 1), the output handshake.
REQ-012 SHALL have port out_imm, output, p_xlen, generated immediate.
REQ-013 SHALL have port out_err, output, 1, set when the entry's type was illegal.
REQ-014 SHALL have port out_tag, output, p_tag_nbits, tag of the entry at the output.

Function
REQ-015 Types SHALL decode as follows: 0 I = sext(inst[31:20]); 1 S = sext({inst[31:25],inst[11:7]}); 2 B = sext({inst[31],inst[7],inst[30:25],inst[11:8],0}); 3 U = sext({inst[31:12],12'b0}); 4 J = sext({inst[31],inst[19:12],inst[20],inst[30:21],0}); 5 CSR-zimm = zext(inst[19:15]); 6 shamt = zext(inst[25:20]), with bit 25 forced to 0 when p_xlen=32; 7 illegal.
REQ-016 Sign extension SHALL replicate inst[31] up to bit p_xlen-1; for U-type with p_xlen=64, bits 63:32 SHALL equal inst[31].
REQ-017 An illegal type SHALL produce imm=0 and err=1; every other type SHALL produce err=0.
REQ-018 Decode SHALL occur before stage 0; stages 1..p_nstages-1 SHALL only carry {val, imm, err, tag}.
REQ-019 A transfer SHALL occur on a side only in a cycle where both its val and rdy are 1.
REQ-020 Stage k SHALL load when it is empty or its contents leave in the same cycle (elastic pipeline with bubble collapse).
REQ-021 in_rdy SHALL be the stage-0 load condition AND NOT squash; in_rdy SHALL NOT depend on in_val.
REQ-022 out_val, out_imm, out_err and out_tag SHALL come directly from the last-stage registers.
REQ-023 Without backpressure, an entry accepted in cycle t SHALL appear at the output in cycle t+p_nstages, with sustained throughput of 1 entry per cycle.
REQ-024 When full with out_rdy=1, a simultaneous input accept and output transfer SHALL occur without a bubble.
REQ-025 While out_rdy=0, out_val and all output data SHALL be held stable until the transfer completes.
REQ-026 Squash SHALL clear every stage valid at the next edge; input presented in the squash cycle SHALL be dropped, and out_val SHALL be 0 in the following cycle.
REQ-027 Entries SHALL exit in acceptance order, and none SHALL be duplicated or lost except by squash.

Reset
REQ-028 Asserting reset (low) SHALL immediately clear all stage valids, forcing out_val=0; out_imm, out_err and out_tag SHALL reset to 0.
REQ-029 Reset asserted mid-operation SHALL discard all entries; after deassertion in_rdy SHALL be 1 in the first cycle.

Structure
REQ-030 Package lab2_proc_imm_pkg SHALL define the 3-bit immediate-type enum (IMM_I..IMM_ILL) and the type constants.
REQ-031 Combinational decode SHALL live in sub-module lab2_proc_imm_decode, parametrised by p_xlen.
REQ-032 Stage registers SHALL be a generate-loop array indexed 0..p_nstages-1.

Verification
REQ-033 Given in_inst=0xFFF00093 with type I and p_xlen=32, the bench SHALL see out_imm=0xFFFFFFFF at t+2 with default depth.
REQ-034 Given in_inst=0x800000EF with type J and p_xlen=64, the bench SHALL see out_imm=0xFFFFFFFFFFF00000.
REQ-035 Given 8 back-to-back entries with tags 0..7 and out_rdy=0 for 3 cycles, the bench SHALL see in_rdy drop after p_nstages entries and tags exit 0..7 in order with no gaps.
REQ-036 Given type 7, the bench SHALL see out_imm=0 and out_err=1; given type 5 with inst[19:15]=5'h1F, it SHALL see out_imm=0x1F.
REQ-037 Given squash with the pipe full and in_val=1, the bench SHALL see out_val=0 in the next cycle and the squash-cycle input never emerge.
REQ-038 Given reset asserted asynchronously between edges, the bench SHALL see out_val=0 before the next edge, then normal flow after release.

Source files
------------

// File: rtl/lab2_proc_imm_pkg.sv
// Shared types and constants for the pipelined RISC-V immediate generator.
package lab2_proc_imm_pkg;

   localparam int unsigned IMM_TYPE_NBITS = 3;
   localparam int unsigned INST_NBITS     = 32;
   localparam int          XLEN_RV64      = 64;

   // Immediate formats selectable at the input; IMM_ILL marks an unusable type.
   typedef enum logic [IMM_TYPE_NBITS-1:0] {
      IMM_I     = 3'd0,
      IMM_S     = 3'd1,
      IMM_B     = 3'd2,
      IMM_U     = 3'd3,
      IMM_J     = 3'd4,
      IMM_CSR   = 3'd5,
      IMM_SHAMT = 3'd6,
      IMM_ILL   = 3'd7
   } imm_type_e;

endpackage

// File: rtl/lab2_proc_imm_decode.sv
// Combinational immediate extraction from a raw 32-bit instruction word.
// The low 32 bits are formed per type; bits above 31 are filled with either
// the instruction sign bit (sign-extending types) or zero (zimm / shamt).
module lab2_proc_imm_decode
   import lab2_proc_imm_pkg::*;
#(
   parameter int p_xlen = 32
) (
   input  logic [IMM_TYPE_NBITS-1:0] i_imm_type,
   input  logic [INST_NBITS-1:0]     i_inst,
   output logic [p_xlen-1:0]         o_imm,
   output logic                      o_err
);

   logic [31:0]       w_imm32;
   logic              w_fill;
   logic              w_shamt_hi;
   logic [p_xlen-1:0] w_imm;

   // Only RV64 uses the sixth shift-amount bit.
   assign w_shamt_hi = (p_xlen == XLEN_RV64) ? i_inst[25] : 1'b0;

   // Select the per-type 32-bit immediate and the fill bit for the upper part.
   always_comb begin
      w_imm32 = 32'h0000_0000;
      w_fill  = 1'b0;
      o_err   = 1'b0;
      case (i_imm_type)
         IMM_I: begin
            w_imm32 = {{20{i_inst[31]}}, i_inst[31:20]};
            w_fill  = i_inst[31];
         end
         IMM_S: begin
            w_imm32 = {{20{i_inst[31]}}, i_inst[31:25], i_inst[11:7]};
            w_fill  = i_inst[31];
         end
         IMM_B: begin
            w_imm32 = {{19{i_inst[31]}}, i_inst[31], i_inst[7], i_inst[30:25], i_inst[11:8], 1'b0};
            w_fill  = i_inst[31];
         end
         IMM_U: begin
            w_imm32 = {i_inst[31:12], 12'h000};
            w_fill  = i_inst[31];
         end
         IMM_J: begin
            w_imm32 = {{11{i_inst[31]}}, i_inst[31], i_inst[19:12], i_inst[20], i_inst[30:21], 1'b0};
            w_fill  = i_inst[31];
         end
         IMM_CSR: begin
            w_imm32 = {27'h000_0000, i_inst[19:15]};
            w_fill  = 1'b0;
         end
         IMM_SHAMT: begin
            w_imm32 = {26'h000_0000, w_shamt_hi, i_inst[24:20]};
            w_fill  = 1'b0;
         end
         default: begin
            w_imm32 = 32'h0000_0000;
            w_fill  = 1'b0;
            o_err   = 1'b1;
         end
      endcase
   end

   // Widen to p_xlen: fill everything with the extension bit, then overlay bits 31:0.
   always_comb begin
      w_imm        = {p_xlen{w_fill}};
      w_imm[31:0]  = w_imm32;
   end

   assign o_imm = w_imm;

endmodule

// File: rtl/lab2_proc_imm_gen_pipe.sv
// Elastic, squashable pipeline around the immediate decoder. Decode happens in
// front of stage 0; later stages only move {val, imm, err, tag}. A stage loads
// when it is empty or its occupant leaves in the same cycle, so bubbles collapse
// and a full pipe streams one entry per cycle.
module lab2_proc_imm_gen_pipe
   import lab2_proc_imm_pkg::*;
#(
   parameter int p_xlen      = 32,
   parameter int p_nstages   = 2,
   parameter int p_tag_nbits = 4
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      squash,
   input  logic                      in_val,
   output logic                      in_rdy,
   input  logic [IMM_TYPE_NBITS-1:0] in_imm_type,
   input  logic [INST_NBITS-1:0]     in_inst,
   input  logic [p_tag_nbits-1:0]    in_tag,
   output logic                      out_val,
   input  logic                      out_rdy,
   output logic [p_xlen-1:0]         out_imm,
   output logic                      out_err,
   output logic [p_tag_nbits-1:0]    out_tag
);

   logic [p_xlen-1:0]      w_dec_imm;
   logic                   w_dec_err;
   logic [p_nstages-1:0]   w_load;
   logic                   w_next_load;

   logic                   r_val [p_nstages];
   logic [p_xlen-1:0]      r_imm [p_nstages];
   logic                   r_err [p_nstages];
   logic [p_tag_nbits-1:0] r_tag [p_nstages];

   lab2_proc_imm_decode #(
      .p_xlen (p_xlen)
   ) u_decode (
      .i_imm_type (in_imm_type),
      .i_inst     (in_inst),
      .o_imm      (w_dec_imm),
      .o_err      (w_dec_err)
   );

   // Load enables ripple back from the output: a stage may load if empty or if the stage after it loads.
   always_comb begin
      w_load      = {p_nstages{1'b0}};
      w_next_load = out_rdy;
      for (int k = p_nstages - 1; k >= 0; k--) begin
         w_load[k]   = !r_val[k] || w_next_load;
         w_next_load = w_load[k];
      end
   end

   assign in_rdy = w_load[0] && !squash;

   for (genvar k = 0; k < p_nstages; k++) begin : g_stage
      logic                   w_src_val;
      logic [p_xlen-1:0]      w_src_imm;
      logic                   w_src_err;
      logic [p_tag_nbits-1:0] w_src_tag;

      if (k == 0) begin : g_head
         assign w_src_val = in_val;
         assign w_src_imm = w_dec_imm;
         assign w_src_err = w_dec_err;
         assign w_src_tag = in_tag;
      end else begin : g_body
         assign w_src_val = r_val[k-1];
         assign w_src_imm = r_imm[k-1];
         assign w_src_err = r_err[k-1];
         assign w_src_tag = r_tag[k-1];
      end

      // Stage register: squash empties it; otherwise it takes upstream contents when allowed to load.
      always_ff @(posedge clk or negedge reset) begin
         if (!reset) begin
            r_val[k] <= 1'b0;
            r_imm[k] <= {p_xlen{1'b0}};
            r_err[k] <= 1'b0;
            r_tag[k] <= {p_tag_nbits{1'b0}};
         end else if (squash) begin
            r_val[k] <= 1'b0;
         end else if (w_load[k]) begin
            r_val[k] <= w_src_val;
            if (w_src_val) begin
               r_imm[k] <= w_src_imm;
               r_err[k] <= w_src_err;
               r_tag[k] <= w_src_tag;
            end
         end
      end
   end

   assign out_val = r_val[p_nstages-1];
   assign out_imm = r_imm[p_nstages-1];
   assign out_err = r_err[p_nstages-1];
   assign out_tag = r_tag[p_nstages-1];

endmodule

// File: tb/tb_lab2_proc_imm_gen_pipe.sv
// Directed self-checking bench: a default (RV32, 2-stage) instance plus an RV64
// instance sharing the same stimulus.
module tb_lab2_proc_imm_gen_pipe;
   import lab2_proc_imm_pkg::*;

   localparam int NSTAGES = 2;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        squash = 1'b0;
   logic        in_val = 1'b0;
   logic [2:0]  in_imm_type = 3'd0;
   logic [31:0] in_inst = 32'h0;
   logic [3:0]  in_tag = 4'h0;
   logic        out_rdy = 1'b1;

   logic        in_rdy, out_val, out_err;
   logic [31:0] out_imm;
   logic [3:0]  out_tag;
   logic        in_rdy64, out_val64, out_err64;
   logic [63:0] out_imm64;
   logic [3:0]  out_tag64;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   lab2_proc_imm_gen_pipe dut (
      .clk(clk), .reset(reset), .squash(squash),
      .in_val(in_val), .in_rdy(in_rdy), .in_imm_type(in_imm_type),
      .in_inst(in_inst), .in_tag(in_tag),
      .out_val(out_val), .out_rdy(out_rdy), .out_imm(out_imm),
      .out_err(out_err), .out_tag(out_tag)
   );

   lab2_proc_imm_gen_pipe #(.p_xlen(64)) dut64 (
      .clk(clk), .reset(reset), .squash(squash),
      .in_val(in_val), .in_rdy(in_rdy64), .in_imm_type(in_imm_type),
      .in_inst(in_inst), .in_tag(in_tag),
      .out_val(out_val64), .out_rdy(out_rdy), .out_imm(out_imm64),
      .out_err(out_err64), .out_tag(out_tag64)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      checks++; if (out_val !== 1'b0) begin failures++; $display("FAIL reset_out_val got=%0b exp=0", out_val); end
      checks++; if (out_imm !== 32'h0) begin failures++; $display("FAIL reset_out_imm got=%h exp=0", out_imm); end
      checks++; if (out_err !== 1'b0) begin failures++; $display("FAIL reset_out_err got=%0b exp=0", out_err); end
      checks++; if (out_tag !== 4'h0) begin failures++; $display("FAIL reset_out_tag got=%h exp=0", out_tag); end
      checks++; if (out_imm64 !== 64'h0) begin failures++; $display("FAIL reset_out_imm64 got=%h exp=0", out_imm64); end
      reset = 1'b1;
      #1;
      checks++; if (in_rdy !== 1'b1) begin failures++; $display("FAIL reset_in_rdy got=%0b exp=1", in_rdy); end
      tick();
   endtask

   task automatic test_decode();
      logic [2:0]  typ [10];
      logic [31:0] inst [10];
      logic [31:0] e32 [10];
      logic [63:0] e64 [10];
      logic        eerr [10];
      typ[0] = IMM_I;     inst[0] = 32'hFFF00093; e32[0] = 32'hFFFFFFFF; e64[0] = 64'hFFFFFFFFFFFFFFFF; eerr[0] = 1'b0;
      typ[1] = IMM_S;     inst[1] = 32'hFE000E00; e32[1] = 32'hFFFFFFFC; e64[1] = 64'hFFFFFFFFFFFFFFFC; eerr[1] = 1'b0;
      typ[2] = IMM_B;     inst[2] = 32'h00000F80; e32[2] = 32'h0000081E; e64[2] = 64'h000000000000081E; eerr[2] = 1'b0;
      typ[3] = IMM_U;     inst[3] = 32'h12345037; e32[3] = 32'h12345000; e64[3] = 64'h0000000012345000; eerr[3] = 1'b0;
      typ[4] = IMM_U;     inst[4] = 32'h80000037; e32[4] = 32'h80000000; e64[4] = 64'hFFFFFFFF80000000; eerr[4] = 1'b0;
      typ[5] = IMM_J;     inst[5] = 32'h800000EF; e32[5] = 32'hFFF00000; e64[5] = 64'hFFFFFFFFFFF00000; eerr[5] = 1'b0;
      typ[6] = IMM_J;     inst[6] = 32'h001000EF; e32[6] = 32'h00000800; e64[6] = 64'h0000000000000800; eerr[6] = 1'b0;
      typ[7] = IMM_CSR;   inst[7] = 32'h800F8073; e32[7] = 32'h0000001F; e64[7] = 64'h000000000000001F; eerr[7] = 1'b0;
      typ[8] = IMM_SHAMT; inst[8] = 32'h83F00013; e32[8] = 32'h0000001F; e64[8] = 64'h000000000000003F; eerr[8] = 1'b0;
      typ[9] = IMM_ILL;   inst[9] = 32'hFFFFFFFF; e32[9] = 32'h00000000; e64[9] = 64'h0000000000000000; eerr[9] = 1'b1;
      out_rdy = 1'b1;
      for (int i = 0; i < 10; i++) begin
         in_val = 1'b1; in_imm_type = typ[i]; in_inst = inst[i]; in_tag = 4'(i);
         tick();
         in_val = 1'b0;
         tick();
         checks++; if (out_val !== 1'b1) begin failures++; $display("FAIL decode_val[%0d] got=%0b exp=1", i, out_val); end
         checks++; if (out_imm !== e32[i]) begin failures++; $display("FAIL decode_imm32[%0d] got=%h exp=%h", i, out_imm, e32[i]); end
         checks++; if (out_imm64 !== e64[i]) begin failures++; $display("FAIL decode_imm64[%0d] got=%h exp=%h", i, out_imm64, e64[i]); end
         checks++; if (out_err !== eerr[i] || out_err64 !== eerr[i]) begin failures++; $display("FAIL decode_err[%0d] got=%0b/%0b exp=%0b", i, out_err, out_err64, eerr[i]); end
         checks++; if (out_tag !== 4'(i)) begin failures++; $display("FAIL decode_tag[%0d] got=%h exp=%h", i, out_tag, 4'(i)); end
      end
      tick();
   endtask

   task automatic test_hold();
      out_rdy = 1'b0;
      in_val = 1'b1; in_imm_type = IMM_I; in_inst = 32'h12300013; in_tag = 4'hA;
      tick();
      in_val = 1'b0;
      tick();
      for (int c = 0; c < 3; c++) begin
         checks++; if (out_val !== 1'b1 || out_imm !== 32'h123 || out_tag !== 4'hA) begin
            failures++; $display("FAIL hold[%0d] got val=%0b imm=%h tag=%h exp val=1 imm=123 tag=a", c, out_val, out_imm, out_tag);
         end
         tick();
      end
      out_rdy = 1'b1;
      #1;
      checks++; if (out_val !== 1'b1 || out_tag !== 4'hA) begin failures++; $display("FAIL hold_release got val=%0b tag=%h exp val=1 tag=a", out_val, out_tag); end
      tick();
      checks++; if (out_val !== 1'b0) begin failures++; $display("FAIL hold_drained got=%0b exp=0", out_val); end
   endtask

   task automatic test_back_to_back();
      int  sent = 0;
      int  recv = 0;
      bit  started = 1'b0;
      bit  acc, xfer;
      for (int cyc = 0; cyc < 40 && recv < 8; cyc++) begin
         out_rdy = (cyc >= 3);
         in_val = (sent < 8);
         in_tag = 4'(sent);
         in_imm_type = IMM_I;
         in_inst = {12'(sent), 20'h00013};
         #1;
         if (cyc == 2) begin
            checks++; if (in_rdy !== 1'b0 || sent != NSTAGES) begin failures++; $display("FAIL b2b_full in_rdy=%0b accepted=%0d exp in_rdy=0 accepted=%0d", in_rdy, sent, NSTAGES); end
         end
         if (cyc == 3) begin
            checks++; if (in_rdy !== 1'b1) begin failures++; $display("FAIL b2b_full_flow in_rdy=%0b exp=1", in_rdy); end
         end
         acc  = in_val && in_rdy;
         xfer = out_val && out_rdy;
         if (xfer) begin
            checks++; if (out_tag !== 4'(recv) || out_imm !== 32'(recv)) begin failures++; $display("FAIL b2b_order got tag=%h imm=%h exp tag=%h", out_tag, out_imm, 4'(recv)); end
            recv++;
            started = 1'b1;
         end else if (started) begin
            checks++; failures++; $display("FAIL b2b_gap at cycle %0d got out_val=%0b exp=1", cyc, out_val);
         end
         tick();
         if (acc) sent++;
      end
      in_val = 1'b0;
      checks++; if (recv != 8) begin failures++; $display("FAIL b2b_count got=%0d exp=8", recv); end
      tick();
   endtask

   task automatic test_squash();
      out_rdy = 1'b0;
      in_imm_type = IMM_I; in_inst = 32'h00100013;
      in_val = 1'b1; in_tag = 4'h1;
      tick();
      in_tag = 4'h2;
      tick();
      checks++; if (out_val !== 1'b1 || out_tag !== 4'h1) begin failures++; $display("FAIL squash_pre got val=%0b tag=%h exp val=1 tag=1", out_val, out_tag); end
      in_tag = 4'h3; squash = 1'b1;
      #1;
      checks++; if (in_rdy !== 1'b0) begin failures++; $display("FAIL squash_in_rdy got=%0b exp=0", in_rdy); end
      tick();
      squash = 1'b0; in_val = 1'b0;
      checks++; if (out_val !== 1'b0) begin failures++; $display("FAIL squash_out_val got=%0b exp=0", out_val); end
      out_rdy = 1'b1;
      for (int c = 0; c < 4; c++) begin
         tick();
         checks++; if (out_val !== 1'b0) begin failures++; $display("FAIL squash_leak[%0d] got val=%0b tag=%h exp val=0", c, out_val, out_tag); end
      end
   endtask

   task automatic test_async_reset();
      out_rdy = 1'b0;
      in_val = 1'b1; in_imm_type = IMM_I; in_inst = 32'h7FF00013; in_tag = 4'h5;
      tick();
      in_val = 1'b0;
      tick();
      checks++; if (out_val !== 1'b1) begin failures++; $display("FAIL areset_pre got=%0b exp=1", out_val); end
      #3 reset = 1'b0;
      #1;
      checks++; if (out_val !== 1'b0 || out_val64 !== 1'b0) begin failures++; $display("FAIL areset_val got=%0b/%0b exp=0", out_val, out_val64); end
      checks++; if (out_imm !== 32'h0 || out_tag !== 4'h0 || out_err !== 1'b0) begin failures++; $display("FAIL areset_data got imm=%h tag=%h err=%0b exp 0", out_imm, out_tag, out_err); end
      #2 reset = 1'b1;
      #1;
      checks++; if (in_rdy !== 1'b1) begin failures++; $display("FAIL areset_in_rdy got=%0b exp=1", in_rdy); end
      out_rdy = 1'b1;
      in_val = 1'b1; in_imm_type = IMM_CSR; in_inst = 32'h00050073; in_tag = 4'h6;
      tick();
      in_val = 1'b0;
      tick();
      checks++; if (out_val !== 1'b1 || out_imm !== 32'h0000000A || out_tag !== 4'h6) begin
         failures++; $display("FAIL areset_flow got val=%0b imm=%h tag=%h exp val=1 imm=0000000a tag=6", out_val, out_imm, out_tag);
      end
      tick();
   endtask

   initial begin
      test_reset();
      test_decode();
      test_hold();
      test_back_to_back();
      test_squash();
      test_async_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
